// File: rtl/ocimem_debug_access_if.sv
// CPU-side Avalon-MM slave bus into the on-chip debug RAM.
// The slave modport is the RAM engine; the master modport is the CPU or its bus fabric.
interface ocimem_debug_access_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;
  logic              avs_readdatavalid;
  logic              avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_readdatavalid, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_readdatavalid, avs_waitrequest
  );
endinterface

// File: rtl/ocimem_debug_access.sv
// Debug memory engine: executes JTAG-side read/write commands on the on-chip debug RAM
// and shares that RAM with a CPU Avalon-MM port; the debug path always wins.
module ocimem_debug_access #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [37:0]                 jdo,
  input  logic                        take_action_ocimem_a,
  input  logic                        take_action_ocimem_b,
  input  logic                        take_no_action_ocimem_a,
  output logic [31:0]                 MonDReg,
  output logic                        monitor_ready,
  output logic                        monitor_error,
  ocimem_debug_access_if.slave        avs
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DRD  = 2'd1;
  localparam logic [1:0] S_DCAP = 2'd2;
  localparam logic [1:0] S_DWR  = 2'd3;

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  logic [1:0]        state;
  logic [ADDR_W-1:0] dbg_addr;
  logic [31:0]       wr_hold;
  logic              strobe_any;
  logic              dbg_in_range;
  logic              cpu_in_range;
  logic              cpu_wr;
  logic              cpu_rd;
  logic              cpu_rd_p1;
  logic              cpu_rd_ok1;

  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_q;
  logic [31:0]       mem [DEPTH];

  logic              jdo_unused;
  assign jdo_unused = ^{jdo[37:35], jdo[2:0]};

  assign strobe_any   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign dbg_in_range = {1'b0, dbg_addr} < DEPTH_LIM;
  assign cpu_in_range = {1'b0, avs.avs_address} < DEPTH_LIM;

  assign avs.avs_waitrequest = (state != S_IDLE) | strobe_any;
  assign cpu_wr = ~avs.avs_waitrequest & avs.avs_write;
  assign cpu_rd = ~avs.avs_waitrequest & avs.avs_read & ~avs.avs_write;

  // The single RAM port goes to the debug FSM in DRD/DWR, otherwise to an accepted CPU access.
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = avs.avs_address;
    ram_wdata = avs.avs_writedata;
    if (state == S_DRD) begin
      ram_re   = dbg_in_range;
      ram_addr = dbg_addr;
    end else if (state == S_DWR) begin
      ram_we    = dbg_in_range;
      ram_addr  = dbg_addr;
      ram_wdata = wr_hold;
    end else begin
      ram_we = cpu_wr & cpu_in_range;
      ram_re = cpu_rd & cpu_in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_q <= mem[ram_addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      dbg_addr      <= '0;
      wr_hold       <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take_action_ocimem_b) begin
            wr_hold       <= jdo[34:3];
            monitor_ready <= 1'b0;
            state         <= S_DWR;
          end else if (take_action_ocimem_a) begin
            dbg_addr <= jdo[17 +: ADDR_W];
            if (jdo[34]) begin
              monitor_ready <= 1'b0;
              state         <= S_DRD;
            end else begin
              monitor_error <= 1'b0;
              monitor_ready <= 1'b1;
            end
          end else if (take_no_action_ocimem_a) begin
            monitor_ready <= 1'b0;
            state         <= S_DRD;
          end
        end
        S_DRD: begin
          if (dbg_in_range) begin
            state <= S_DCAP;
          end else begin
            monitor_error <= 1'b1;
            MonDReg       <= '0;
            monitor_ready <= 1'b1;
            dbg_addr      <= dbg_addr + 1'b1;
            state         <= S_IDLE;
          end
        end
        S_DCAP: begin
          MonDReg       <= ram_q;
          monitor_error <= 1'b0;
          monitor_ready <= 1'b1;
          dbg_addr      <= dbg_addr + 1'b1;
          state         <= S_IDLE;
        end
        S_DWR: begin
          if (dbg_in_range) begin
            MonDReg       <= wr_hold;
            monitor_error <= 1'b0;
          end else begin
            monitor_error <= 1'b1;
          end
          monitor_ready <= 1'b1;
          dbg_addr      <= dbg_addr + 1'b1;
          state         <= S_IDLE;
        end
      endcase
    end
  end

  // CPU reads: RAM output lands one cycle after acceptance, readdata is registered one more.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_rd_p1             <= 1'b0;
      cpu_rd_ok1            <= 1'b0;
      avs.avs_readdata      <= '0;
      avs.avs_readdatavalid <= 1'b0;
    end else begin
      cpu_rd_p1             <= cpu_rd;
      cpu_rd_ok1            <= cpu_in_range;
      avs.avs_readdatavalid <= cpu_rd_p1;
      if (cpu_rd_p1) avs.avs_readdata <= cpu_rd_ok1 ? ram_q : 32'd0;
    end
  end

endmodule

// File: tb/tb_ocimem_debug_access.sv
// Scoreboard bench for ocimem_debug_access: stimulus pushes expected results computed from a
// word-array memory model, an independent negedge monitor pops and compares.
module tb_ocimem_debug_access;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 200;
  localparam int NWORDS = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        ta_a = 1'b0;
  logic        ta_b = 1'b0;
  logic        tna_a = 1'b0;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  ocimem_debug_access_if #(.ADDR_W(ADDR_W)) avs ();

  ocimem_debug_access #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta_a),
    .take_action_ocimem_b    (ta_b),
    .take_no_action_ocimem_a (tna_a),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .avs                     (avs)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int issue; int due; logic [31:0] mon; logic err; } dbg_exp_t;
  typedef struct { int due; logic [31:0] data; } cpu_exp_t;
  dbg_exp_t dbg_q[$];
  cpu_exp_t cpu_q[$];

  logic [31:0] mem_model [NWORDS];
  int unsigned m_addr = 0;
  logic [31:0] m_mon = '0;
  logic        m_err = 1'b0;
  int          busy_until = -1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: compares DUT outputs against queued expectations, independent of stimulus.
  cpu_exp_t ce;
  always @(negedge clk) begin
    if (reset_n) begin
      checkOutput("waitrequest", 32'(avs.avs_waitrequest), 32'(cyc <= busy_until));
      if (dbg_q.size() > 0) begin
        if (cyc == dbg_q[0].due) begin
          checkOutput("monitor_ready", 32'(monitor_ready), 32'd1);
          checkOutput("MonDReg", MonDReg, dbg_q[0].mon);
          checkOutput("monitor_error", 32'(monitor_error), 32'(dbg_q[0].err));
          void'(dbg_q.pop_front());
        end else if (cyc > dbg_q[0].issue && cyc < dbg_q[0].due) begin
          checkOutput("monitor_ready_busy", 32'(monitor_ready), 32'd0);
        end
      end
      if (avs.avs_readdatavalid) begin
        if (cpu_q.size() == 0) begin
          checkOutput("readdatavalid_unexpected", 32'(avs.avs_readdatavalid), 32'd0);
        end else begin
          ce = cpu_q.pop_front();
          checkOutput("readdata_latency", 32'(cyc), 32'(ce.due));
          checkOutput("readdata", avs.avs_readdata, ce.data);
        end
      end else if (cpu_q.size() > 0 && cyc >= cpu_q[0].due) begin
        checkOutput("readdatavalid_missing", 32'(avs.avs_readdatavalid), 32'd1);
        void'(cpu_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0;
    avs.avs_read = 1'b0; avs.avs_write = 1'b0;
    avs.avs_address = '0; avs.avs_writedata = '0;
    dbg_q.delete(); cpu_q.delete();
    m_addr = 0; m_mon = '0; m_err = 1'b0; busy_until = -1;
    repeat (2) @(negedge clk);
    checkOutput("rst_MonDReg", MonDReg, 32'd0);
    checkOutput("rst_monitor_ready", 32'(monitor_ready), 32'd0);
    checkOutput("rst_monitor_error", 32'(monitor_error), 32'd0);
    checkOutput("rst_readdata", avs.avs_readdata, 32'd0);
    checkOutput("rst_readdatavalid", 32'(avs.avs_readdatavalid), 32'd0);
    checkOutput("rst_waitrequest", 32'(avs.avs_waitrequest), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // One debug command issued in the current cycle; the model applies the command rules directly.
  task automatic applyStimulus(input logic do_a, input logic do_b, input logic do_na,
                               input logic [ADDR_W-1:0] addr, input logic rd, input logic [31:0] wdata);
    int k;
    int lat;
    k = cyc;
    lat = 1;
    jdo = {6'($urandom()), $urandom()};
    jdo[17 +: ADDR_W] = addr;
    jdo[34] = rd;
    if (do_b) jdo[34:3] = wdata;
    if (do_b) begin
      if (m_addr < DEPTH) begin
        mem_model[m_addr] = wdata; m_mon = wdata; m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
      m_addr = (m_addr + 1) % NWORDS;
      lat = 2;
    end else if (do_a && !rd) begin
      m_addr = addr; m_err = 1'b0; lat = 1;
    end else if (do_a || do_na) begin
      if (do_a) m_addr = addr;
      if (m_addr < DEPTH) begin
        m_mon = mem_model[m_addr]; m_err = 1'b0; lat = 3;
      end else begin
        m_mon = '0; m_err = 1'b1; lat = 2;
      end
      m_addr = (m_addr + 1) % NWORDS;
    end
    busy_until = k + lat - 1;
    dbg_q.push_back('{k, k + lat, m_mon, m_err});
    ta_a = do_a; ta_b = do_b; tna_a = do_na;
    @(posedge clk); #1;
    ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0;
    jdo = {6'($urandom()), $urandom()};
    repeat (lat + 3) @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data, output int stalls);
    stalls = 0;
    avs.avs_address = addr; avs.avs_writedata = data; avs.avs_write = 1'b1;
    @(negedge clk);
    while (avs.avs_waitrequest && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (avs.avs_waitrequest) checkOutput("cpu_write_accept", 32'(avs.avs_waitrequest), 32'd0);
    else if (int'(addr) < DEPTH) mem_model[addr] = data;
    @(posedge clk); #1;
    avs.avs_write = 1'b0;
  endtask

  task automatic cpu_read(input logic [ADDR_W-1:0] addr);
    int n;
    n = 0;
    avs.avs_address = addr; avs.avs_read = 1'b1;
    @(negedge clk);
    while (avs.avs_waitrequest && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (avs.avs_waitrequest) checkOutput("cpu_read_accept", 32'(avs.avs_waitrequest), 32'd0);
    else cpu_q.push_back('{cyc + 2, (int'(addr) < DEPTH) ? mem_model[addr] : 32'd0});
    @(posedge clk); #1;
    avs.avs_read = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          stalls;
    int          op;
    logic [7:0]  ra;
    logic [31:0] rdat;
    logic [31:0] held;

    do_reset();
    for (int i = 0; i < DEPTH; i++) cpu_write(8'(i), $urandom(), stalls);
    cpu_write(8'hD0, 32'h1234_5678, stalls);
    cpu_read(8'hD0);

    applyStimulus(1, 0, 0, 8'h10, 0, 0);
    applyStimulus(0, 1, 0, 8'h00, 0, 32'hDEAD_BEEF);
    applyStimulus(1, 0, 0, 8'h10, 1, 0);
    cpu_read(8'h10);

    applyStimulus(1, 0, 0, 8'h20, 0, 0);
    for (int i = 1; i <= 3; i++) applyStimulus(0, 1, 0, 8'h00, 0, 32'(i));
    applyStimulus(1, 0, 0, 8'h20, 1, 0);
    applyStimulus(0, 0, 1, 8'h00, 0, 0);
    applyStimulus(0, 0, 1, 8'h00, 0, 0);
    applyStimulus(0, 0, 1, 8'h00, 0, 0);

    applyStimulus(1, 0, 0, 8'hC8, 1, 0);
    cpu_read(8'hC8);
    cpu_read(8'hC7);
    applyStimulus(1, 0, 0, 8'h00, 1, 0);

    held = 32'hCAFE_F00D;
    fork
      applyStimulus(1, 0, 0, 8'h40, 1, 0);
      cpu_write(8'h41, held, stalls);
    join
    checkOutput("cpu_write_stall_cycles", 32'(stalls), 32'd3);
    cpu_read(8'h41);
    applyStimulus(1, 0, 0, 8'h41, 1, 0);

    applyStimulus(1, 0, 0, 8'h50, 0, 0);
    applyStimulus(1, 1, 0, 8'h77, 1, 32'h0BAD_CAFE);
    applyStimulus(1, 0, 0, 8'h50, 1, 0);
    applyStimulus(1, 0, 1, 8'h60, 0, 0);
    applyStimulus(0, 0, 1, 8'h00, 0, 0);

    applyStimulus(1, 0, 0, 8'hFF, 0, 0);
    applyStimulus(0, 1, 0, 8'h00, 0, 32'hAAAA_0001);
    applyStimulus(0, 1, 0, 8'h00, 0, 32'h5555_0002);
    applyStimulus(1, 0, 0, 8'h00, 1, 0);
    cpu_read(8'h00);

    for (int i = 0; i < 150; i++) begin
      op   = int'($urandom_range(0, 5));
      ra   = 8'($urandom_range(0, 255));
      rdat = $urandom();
      case (op)
        0: applyStimulus(1, 0, 0, ra, 1'($urandom_range(0, 1)), 0);
        1: applyStimulus(0, 0, 1, 8'h00, 0, 0);
        2: applyStimulus(0, 1, 0, 8'h00, 0, rdat);
        3: applyStimulus(1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)), ra, 0, rdat);
        4: cpu_read(ra);
        default: cpu_write(ra, rdat, stalls);
      endcase
    end

    // Reset during DWR must lose the pending write.
    applyStimulus(1, 0, 0, 8'h30, 0, 0);
    jdo = {3'b000, 32'hBAD0_BAD0, 3'b000};
    ta_b = 1'b1;
    busy_until = cyc + 1;
    @(posedge clk); #1;
    ta_b = 1'b0;
    reset_n = 1'b0;
    do_reset();
    cpu_read(8'h30);

    // Reset between CPU read acceptance and readdatavalid must suppress the response.
    avs.avs_address = 8'h10; avs.avs_read = 1'b1;
    @(posedge clk); #1;
    avs.avs_read = 1'b0;
    reset_n = 1'b0;
    do_reset();
    repeat (3) begin
      @(negedge clk);
      checkOutput("readdatavalid_after_reset", 32'(avs.avs_readdatavalid), 32'd0);
    end

    repeat (6) @(posedge clk);
    #1;
    checkOutput("dbg_queue_drained", 32'(dbg_q.size()), 32'd0);
    checkOutput("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
